data_io_packer: RTL and testbench
=================================

// Module: data_io_packer
// PURPOSE
//  Download write-path for wide cores. Takes the byte stream already brought into the
//  clk_sys domain from the io-controller SPI link and packs it into DW_BYTES-wide words
//  with byte enables. Words are buffered in a FIFO so the core can stall with ioctl_wait,
//  and a partial last word is flushed at end of download. Sits between the SPI byte
//  receiver and the core's ROM/RAM loader.
// PARAMETERS
//  DW_BYTES    2       word width in bytes: 1, 2, 4 or 8
//  FIFO_DEPTH  4       word FIFO depth, power of 2, >= 2
//  START_ADDR  27'd0   first write address, must be DW_BYTES-aligned
//  BIG_ENDIAN  1'b0    0: first byte goes to lane 0 (LSB); 1: first byte goes to top lane
//  USE_CLKREF  1'b1    1: issue writes only in cycles with clkref_n=0; 0: ignore clkref_n
// PORTS
//  clk_sys         in   1            system clock
//  reset           in   1            asynchronous reset, active high
//  clkref_n        in   1            write slot strobe, active low
//  dl_start        in   1            1-cycle pulse: download begins
//  dl_end          in   1            1-cycle pulse: last byte delivered
//  byte_stb        in   1            1-cycle pulse: byte_data valid
//  byte_data       in   8            downloaded byte
//  ioctl_wait      in   1            core stall; no write is issued while high
//  ioctl_download  out  1            download active, including FIFO drain
//  ioctl_wr        out  1            1-cycle write strobe
//  ioctl_addr      out  27           byte address of ioctl_dout lane 0
//  ioctl_dout      out  8*DW_BYTES   packed word
//  ioctl_be        out  DW_BYTES     byte enables, bit i = lane i
//  overflow        out  1            sticky: a word was dropped because the FIFO was full
// BEHAVIOUR
//  - Reset (async): all outputs 0, ioctl_addr=0, internal address=START_ADDR, FIFO empty,
//    lane counter k=0. A reset mid-download aborts it; nothing is written afterwards.
//  - dl_start: clears packer, FIFO and overflow; address=START_ADDR; ioctl_download=1
//    from the next cycle. dl_start while already downloading restarts: pending partial
//    word and FIFO contents are discarded.
//  - byte_stb while ioctl_download=1 and not ending: byte written to lane k
//    (lane DW_BYTES-1-k if BIG_ENDIAN). k then increments. When k=DW_BYTES-1 the word is
//    pushed with be=all ones and k wraps to 0. byte_stb while idle is ignored.
//  - FIFO push when full: word dropped, overflow=1 until the next dl_start or reset.
//    Push and pop in the same cycle when full is legal; nothing is dropped.
//  - Write issue: FIFO non-empty & !ioctl_wait & (clkref_n==0 | !USE_CLKREF).
//    Registered outputs: ioctl_wr=1 for one cycle, with ioctl_addr=address and
//    dout/be from the FIFO head. Address += DW_BYTES, 27-bit wrap. Back-to-back writes
//    on consecutive eligible cycles are allowed. dout/addr/be hold between writes.
//  - Latency: with no stall and clkref_n=0, ioctl_wr is high in the 2nd cycle after the
//    byte_stb that completes a word (push edge, then issue edge).
//  - dl_end: if k>0, the partial word is pushed with be set for filled lanes only;
//    unfilled lanes read 0. dl_end and byte_stb in the same cycle: the byte is packed
//    first, then the flush happens. Later byte_stb is ignored until dl_start.
//    ioctl_download falls the cycle after the final ioctl_wr, or the cycle after dl_end
//    if nothing is pending. dl_end while idle is ignored.
//  - ioctl_wait is sampled every cycle and may toggle freely; words are never reordered
//    or duplicated.
// TESTING
//  1 DW=2,LE: dl_start; bytes 11,22,33,44; dl_end -> wr @0 dout=16'h2211 be=2'b11,
//    wr @2 dout=16'h4433; ioctl_download falls after the second wr.
//  2 DW=4,BE: bytes AA,BB,CC,DD,EE; dl_end -> @0 32'hAABBCCDD be=4'hF;
//    @4 32'hEE000000 be=4'b1000.
//  3 DW=1,DEPTH=4: ioctl_wait=1; 6 bytes -> overflow=1; release -> exactly 4 writes,
//    addr 0..3, bytes 1..4.
//  4 USE_CLKREF=1, clkref_n low 1 cycle in 4, 8-byte download -> every ioctl_wr
//    coincides with a clkref_n=0 slot.
//  5 Reset after 3 bytes (DW=2) -> all outputs 0 immediately, no further wr;
//    new dl_start -> first wr @START_ADDR.
//  6 dl_start mid-download with one byte pending -> byte discarded; next word
//    written @START_ADDR, overflow=0.

Source files
------------

// File: rtl/data_io_packer_if.sv
// Byte-download and word-write signals of the download packer.
// The master modport is the packer itself; slave is the byte source and the core.
interface data_io_packer_if #(
    parameter int DW_BYTES = 2
);
    logic                    clkref_n;
    logic                    dl_start;
    logic                    dl_end;
    logic                    byte_stb;
    logic [7:0]              byte_data;
    logic                    ioctl_wait;
    logic                    ioctl_download;
    logic                    ioctl_wr;
    logic [26:0]             ioctl_addr;
    logic [8*DW_BYTES-1:0]   ioctl_dout;
    logic [DW_BYTES-1:0]     ioctl_be;
    logic                    overflow;

    modport master (
        input  clkref_n, dl_start, dl_end, byte_stb, byte_data, ioctl_wait,
        output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_be, overflow
    );

    modport slave (
        output clkref_n, dl_start, dl_end, byte_stb, byte_data, ioctl_wait,
        input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_be, overflow
    );
endinterface

// File: rtl/data_io_packer.sv
// Packs downloaded bytes into DW_BYTES-wide words with byte enables and issues them
// to the core through a word FIFO; a partial last word is flushed at end of download.
module data_io_packer #(
    parameter int          DW_BYTES   = 2,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [26:0] START_ADDR = 27'd0,
    parameter logic        BIG_ENDIAN = 1'b0,
    parameter logic        USE_CLKREF = 1'b1
) (
    input logic              clk_sys,
    input logic              reset,
    data_io_packer_if.master bus
);
    localparam int              KW        = (DW_BYTES > 1) ? $clog2(DW_BYTES) : 1;
    localparam int              AW        = $clog2(FIFO_DEPTH);
    localparam int              WW        = 8 * DW_BYTES;
    localparam logic [KW-1:0]   K_LAST    = KW'(DW_BYTES - 1);
    localparam logic [26:0]     ADDR_STEP = 27'(DW_BYTES);
    localparam logic [AW:0]     FIFO_FULL = (AW + 1)'(FIFO_DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]          r_state;
    logic [KW-1:0]       r_k;
    logic [WW-1:0]       r_word;
    logic [DW_BYTES-1:0] r_be;
    logic [AW:0]         r_wptr;
    logic [AW:0]         r_rptr;
    logic [26:0]         r_addr;
    logic                r_wr;
    logic [26:0]         r_out_addr;
    logic [WW-1:0]       r_out_dout;
    logic [DW_BYTES-1:0] r_out_be;
    logic                r_overflow;
    logic [WW-1:0]       r_fifo_dout [FIFO_DEPTH];
    logic [DW_BYTES-1:0] r_fifo_be   [FIFO_DEPTH];

    logic                w_byte_ok;
    logic                w_end_ok;
    logic [KW-1:0]       w_lane;
    logic [KW-1:0]       w_k_next;
    logic [WW-1:0]       w_word;
    logic [DW_BYTES-1:0] w_be;
    logic                w_push;
    logic                w_push_ok;
    logic                w_pop;
    logic [AW:0]         w_count;
    logic [AW:0]         w_count_next;
    logic                w_done;

    // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        w_byte_ok = bus.byte_stb & (r_state == S_LOAD);
        w_end_ok  = bus.dl_end & (r_state == S_LOAD);
        w_lane    = BIG_ENDIAN ? (K_LAST - r_k) : r_k;
        w_word    = r_word;
        w_be      = r_be;
        if (w_byte_ok) begin
            w_word[w_lane*8 +: 8] = bus.byte_data;
            w_be[w_lane]          = 1'b1;
        end
        w_k_next = r_k;
        if (w_byte_ok) w_k_next = (r_k == K_LAST) ? '0 : r_k + 1'b1;
        // A byte completing a word leaves nothing to flush, so both pushes never coincide.
        w_push       = (w_byte_ok & (r_k == K_LAST)) | (w_end_ok & (w_k_next != '0));
        w_count      = r_wptr - r_rptr;
        w_pop        = (r_state != S_IDLE) & (w_count != '0) & ~bus.ioctl_wait
                     & (~bus.clkref_n | ~USE_CLKREF);
        w_push_ok    = w_push & ((w_count != FIFO_FULL) | w_pop);
        w_count_next = w_count + (AW + 1)'(w_push_ok) - (AW + 1)'(w_pop);
        w_done       = ((r_state == S_DRAIN) | w_end_ok) & (w_count_next == '0) & ~w_pop;
    end

    // NOTE: the word storage has no reset; the pointers alone define what is valid.
    always_ff @(posedge clk_sys) begin
        if (w_push_ok) begin
            r_fifo_dout[r_wptr[AW-1:0]] <= w_word;
            r_fifo_be[r_wptr[AW-1:0]]   <= w_be;
        end
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_k        <= '0;
            r_word     <= '0;
            r_be       <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_addr     <= START_ADDR;
            r_wr       <= 1'b0;
            r_out_addr <= '0;
            r_out_dout <= '0;
            r_out_be   <= '0;
            r_overflow <= 1'b0;
        end else if (bus.dl_start) begin
            r_state    <= S_LOAD;
            r_k        <= '0;
            r_word     <= '0;
            r_be       <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_addr     <= START_ADDR;
            r_wr       <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_wr <= w_pop;
            if (w_pop) begin
                r_out_addr <= r_addr;
                r_out_dout <= r_fifo_dout[r_rptr[AW-1:0]];
                r_out_be   <= r_fifo_be[r_rptr[AW-1:0]];
                r_addr     <= r_addr + ADDR_STEP;
                r_rptr     <= r_rptr + 1'b1;
            end
            if (w_push_ok) r_wptr <= r_wptr + 1'b1;
            if (w_push && !w_push_ok) r_overflow <= 1'b1;
            r_k    <= w_k_next;
            r_word <= w_push ? '0 : w_word;
            r_be   <= w_push ? '0 : w_be;
            if (w_done)        r_state <= S_IDLE;
            else if (w_end_ok) r_state <= S_DRAIN;
        end
    end

    assign bus.ioctl_download = (r_state != S_IDLE);
    assign bus.ioctl_wr       = r_wr;
    assign bus.ioctl_addr     = r_out_addr;
    assign bus.ioctl_dout     = r_out_dout;
    assign bus.ioctl_be       = r_out_be;
    assign bus.overflow       = r_overflow;
endmodule

// File: tb/tb_data_io_packer.sv
// Drives one byte stream into two packer configurations (16-bit little-endian with
// write slots, 32-bit big-endian wrapping at the top of the address space).
module tb_data_io_packer;
    localparam logic [26:0] START_B = 27'h7FFFFF8;

    typedef struct packed {
        logic [26:0] addr;
        logic [63:0] dout;
        logic [7:0]  be;
        logic        ref_ok;
    } wr_t;
    typedef wr_t        wr_q_t[$];
    typedef logic [7:0] byte_q_t[$];

    logic       clk_sys = 1'b0;
    logic       reset = 1'b0;
    logic       clkref_n = 1'b1;
    logic       dl_start = 1'b0;
    logic       dl_end = 1'b0;
    logic       byte_stb = 1'b0;
    logic [7:0] byte_data = 8'h00;
    logic       ioctl_wait = 1'b0;
    int         wait_mode = 0;
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         last_wr_a = -1;
    int         fall_a = -1;
    wr_q_t      qa;
    wr_q_t      qb;

    always #5 clk_sys = ~clk_sys;

    data_io_packer_if #(.DW_BYTES(2)) if_a ();
    data_io_packer_if #(.DW_BYTES(4)) if_b ();

    assign if_a.clkref_n = clkref_n;   assign if_b.clkref_n = clkref_n;
    assign if_a.dl_start = dl_start;   assign if_b.dl_start = dl_start;
    assign if_a.dl_end = dl_end;       assign if_b.dl_end = dl_end;
    assign if_a.byte_stb = byte_stb;   assign if_b.byte_stb = byte_stb;
    assign if_a.byte_data = byte_data; assign if_b.byte_data = byte_data;
    assign if_a.ioctl_wait = ioctl_wait; assign if_b.ioctl_wait = ioctl_wait;

    data_io_packer #(.DW_BYTES(2), .FIFO_DEPTH(4), .START_ADDR(27'd0),
                     .BIG_ENDIAN(1'b0), .USE_CLKREF(1'b1))
        dut_a (.clk_sys(clk_sys), .reset(reset), .bus(if_a));
    data_io_packer #(.DW_BYTES(4), .FIFO_DEPTH(2), .START_ADDR(START_B),
                     .BIG_ENDIAN(1'b1), .USE_CLKREF(1'b0))
        dut_b (.clk_sys(clk_sys), .reset(reset), .bus(if_b));

    // Write slot one cycle in four, and the optional random core stall.
    initial begin
        int n = 0;
        forever begin
            @(posedge clk_sys); #1;
            n = n + 1;
            clkref_n = (n % 4) != 0;
            if (wait_mode == 1)      ioctl_wait = ($urandom_range(3) == 0);
            else if (wait_mode == 2) ioctl_wait = 1'b1;
            else                     ioctl_wait = 1'b0;
        end
    end

    // Write collector; a write issued by A must follow a cycle with clkref_n low.
    initial begin
        logic ref_prev = 1'b1;
        logic dl_prev = 1'b0;
        forever begin
            @(negedge clk_sys);
            cyc = cyc + 1;
            if (if_a.ioctl_wr === 1'b1) begin
                qa.push_back('{addr: if_a.ioctl_addr, dout: 64'(if_a.ioctl_dout),
                               be: 8'(if_a.ioctl_be), ref_ok: !ref_prev});
                last_wr_a = cyc;
            end
            if (dl_prev && !if_a.ioctl_download) fall_a = cyc;
            dl_prev = if_a.ioctl_download;
            if (if_b.ioctl_wr === 1'b1)
                qb.push_back('{addr: if_b.ioctl_addr, dout: 64'(if_b.ioctl_dout),
                               be: 8'(if_b.ioctl_be), ref_ok: 1'b1});
            ref_prev = clkref_n;
        end
    end

    // Expected writes: bytes fill lanes in arrival order, one word per dw bytes,
    // addresses step by dw from start; only the first 'keep' words survive.
    function automatic wr_q_t model(byte_q_t b, int dw, bit big, logic [26:0] start, int keep);
        wr_q_t r;
        int    nw = (b.size() + dw - 1) / dw;
        for (int w = 0; w < nw && w < keep; w++) begin
            wr_t e = '0;
            e.addr   = start + 27'(w * dw);
            e.ref_ok = 1'b1;
            for (int j = 0; j < dw; j++) begin
                int lane = big ? dw - 1 - j : j;
                if (w * dw + j < b.size()) begin
                    e.dout[lane*8 +: 8] = b[w*dw+j];
                    e.be[lane]          = 1'b1;
                end
            end
            r.push_back(e);
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk_sys); #1;
    endtask

    task automatic drive_download(input byte_q_t b, input int gap, input bit end_with_last);
        qa.delete();
        qb.delete();
        dl_start = 1'b1; tick(); dl_start = 1'b0;
        for (int i = 0; i < b.size(); i++) begin
            byte_stb  = 1'b1;
            byte_data = b[i];
            dl_end    = end_with_last && (i == b.size() - 1);
            tick();
            byte_stb = 1'b0;
            dl_end   = 1'b0;
            repeat (gap) tick();
        end
        if (!end_with_last) begin
            dl_end = 1'b1; tick(); dl_end = 1'b0;
            // Late byte after dl_end must be ignored.
            byte_stb = 1'b1; byte_data = 8'h5A; tick(); byte_stb = 1'b0;
        end
    endtask

    task automatic finish_and_compare(input string tag, input byte_q_t b,
                                      input int keep_a, input int keep_b);
        wr_q_t ea = model(b, 2, 1'b0, 27'd0, keep_a);
        wr_q_t eb = model(b, 4, 1'b1, START_B, keep_b);
        int    n = 0;
        while ((if_a.ioctl_download || if_b.ioctl_download) && n < 3000) begin
            tick();
            n++;
        end
        repeat (2) tick();
        total++;
        if (n >= 3000) begin
            bad++;
            $display("FAIL %s drain_timeout got=busy exp=idle", tag);
        end
        total++;
        if (qa.size() != ea.size() || qb.size() != eb.size()) begin
            bad++;
            $display("FAIL %s write_count got=%0d/%0d exp=%0d/%0d",
                     tag, qa.size(), qb.size(), ea.size(), eb.size());
        end
        for (int i = 0; i < ea.size() && i < qa.size(); i++) begin
            total++;
            if (qa[i] !== ea[i]) begin
                bad++;
                $display("FAIL %s a_word%0d got=%h exp=%h", tag, i, qa[i], ea[i]);
            end
        end
        for (int i = 0; i < eb.size() && i < qb.size(); i++) begin
            total++;
            if (qb[i] !== eb[i]) begin
                bad++;
                $display("FAIL %s b_word%0d got=%h exp=%h", tag, i, qb[i], eb[i]);
            end
        end
    endtask

    task automatic test_reset();
        #2 reset = 1'b1;
        #1;
        total++;
        if ({if_a.ioctl_download, if_a.ioctl_wr, if_a.ioctl_addr, if_a.ioctl_dout,
             if_a.ioctl_be, if_a.overflow} !== '0) begin
            bad++;
            $display("FAIL reset_a got=%b%b %h %h %b %b exp=all_zero", if_a.ioctl_download,
                     if_a.ioctl_wr, if_a.ioctl_addr, if_a.ioctl_dout, if_a.ioctl_be, if_a.overflow);
        end
        total++;
        if ({if_b.ioctl_download, if_b.ioctl_wr, if_b.ioctl_addr, if_b.ioctl_dout,
             if_b.ioctl_be, if_b.overflow} !== '0) begin
            bad++;
            $display("FAIL reset_b got=%b%b %h %h %b %b exp=all_zero", if_b.ioctl_download,
                     if_b.ioctl_wr, if_b.ioctl_addr, if_b.ioctl_dout, if_b.ioctl_be, if_b.overflow);
        end
        repeat (3) tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_full_words();
        byte_q_t b = '{8'h11, 8'h22, 8'h33, 8'h44};
        drive_download(b, 0, 1'b0);
        finish_and_compare("full_words", b, 99, 99);
        total++;
        if (fall_a != last_wr_a + 1) begin
            bad++;
            $display("FAIL download_fall got=%0d exp=%0d", fall_a, last_wr_a + 1);
        end
    endtask

    task automatic test_partial_flush();
        byte_q_t b = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
        drive_download(b, 1, 1'b0);
        finish_and_compare("partial", b, 99, 99);
        total++;
        if (qb.size() < 2 || qb[1].dout !== 64'hEE000000 || qb[1].be !== 8'h08) begin
            bad++;
            $display("FAIL partial_b_last got=%h exp=dout 000000ee000000 be 08",
                     (qb.size() > 1) ? qb[1] : '0);
        end
    endtask

    task automatic test_random_streams();
        for (int it = 0; it < 6; it++) begin
            byte_q_t b;
            int      len = $urandom_range(13, 1);
            for (int i = 0; i < len; i++) b.push_back(8'($urandom));
            wait_mode = 1;
            byte_stb = 1'b1; byte_data = 8'hC3; tick(); byte_stb = 1'b0;
            drive_download(b, $urandom_range(12, 8), 1'($urandom_range(1)));
            finish_and_compare($sformatf("random%0d", it), b, 99, 99);
            total++;
            if (if_a.overflow !== 1'b0 || if_b.overflow !== 1'b0) begin
                bad++;
                $display("FAIL random%0d_overflow got=%b%b exp=00", it, if_a.overflow, if_b.overflow);
            end
        end
        wait_mode = 0;
    endtask

    task automatic test_overflow();
        byte_q_t b;
        for (int i = 0; i < 10; i++) b.push_back(8'(i + 1));
        wait_mode = 2;
        tick();
        drive_download(b, 0, 1'b0);
        total++;
        if (if_a.overflow !== 1'b1 || if_b.overflow !== 1'b1 || qa.size() != 0 || qb.size() != 0) begin
            bad++;
            $display("FAIL overflow_stalled got=%b%b wr=%0d/%0d exp=11 wr=0/0",
                     if_a.overflow, if_b.overflow, qa.size(), qb.size());
        end
        wait_mode = 0;
        finish_and_compare("overflow", b, 4, 2);
        total++;
        if (if_a.overflow !== 1'b1 || if_b.overflow !== 1'b1) begin
            bad++;
            $display("FAIL overflow_sticky got=%b%b exp=11", if_a.overflow, if_b.overflow);
        end
    endtask

    task automatic test_restart();
        byte_q_t b = '{8'h21, 8'h43, 8'h65, 8'h87, 8'hA9};
        dl_start = 1'b1; tick(); dl_start = 1'b0;
        byte_stb = 1'b1; byte_data = 8'hF0; tick(); byte_stb = 1'b0;
        drive_download(b, 2, 1'b1);
        finish_and_compare("restart", b, 99, 99);
        total++;
        if (if_a.overflow !== 1'b0 || if_b.overflow !== 1'b0) begin
            bad++;
            $display("FAIL restart_overflow got=%b%b exp=00", if_a.overflow, if_b.overflow);
        end
    endtask

    task automatic test_reset_mid_download();
        byte_q_t b = '{8'h01, 8'h02, 8'h03, 8'h04};
        dl_start = 1'b1; tick(); dl_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            byte_stb = 1'b1; byte_data = 8'h70 + 8'(i); tick(); byte_stb = 1'b0;
        end
        repeat (8) tick();
        reset = 1'b1;
        #1;
        total++;
        if ({if_a.ioctl_download, if_a.ioctl_wr, if_a.ioctl_addr, if_a.ioctl_dout,
             if_a.ioctl_be, if_a.overflow} !== '0 || if_b.ioctl_download !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid got=%b%b %h %h %b %b dl_b=%b exp=all_zero", if_a.ioctl_download,
                     if_a.ioctl_wr, if_a.ioctl_addr, if_a.ioctl_dout, if_a.ioctl_be,
                     if_a.overflow, if_b.ioctl_download);
        end
        tick();
        reset = 1'b0;
        qa.delete();
        qb.delete();
        repeat (20) tick();
        total++;
        if (qa.size() != 0 || qb.size() != 0) begin
            bad++;
            $display("FAIL reset_mid_no_write got=%0d/%0d exp=0/0", qa.size(), qb.size());
        end
        drive_download(b, 0, 1'b0);
        finish_and_compare("after_reset", b, 99, 99);
    endtask

    initial begin
        test_reset();
        test_full_words();
        test_partial_flush();
        test_random_streams();
        test_overflow();
        test_restart();
        test_reset_mid_download();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
